sar_div_arbiter: RTL and testbench
==================================

// Module: sar_div_arbiter
// PURPOSE
//   Shares one sar_divisor_module core among N_REQ requesters with round-robin arbitration.
//   Per grant, the block:
//   - accepts one divide request and latches its operands;
//   - pulses the core's start/reset pin and holds the operands stable;
//   - waits for the core's ready and returns the quotient to the granted requester.
//   It sits between the processing blocks and the single divider instance.
// PARAMETERS
//   BITS           16   operand/result width; must match the divider core
//   N_REQ          4    number of requesters (2..8)
//   TIMEOUT_CYCLES 4096 watchdog limit in WAIT cycles; used only with SAR_DIV_ARB_TIMEOUT_EN
// PORTS
//   clk          in   1           clock, rising edge
//   reset        in   1           synchronous, active-high
//   req_valid    in   N_REQ       per-requester request valid
//   req_ready    out  N_REQ       one-hot accept; a request transfers when valid&ready
//   req_dividend in   N_REQ*BITS  packed dividends, requester i at [i*BITS +: BITS]
//   req_divisor  in   N_REQ*BITS  packed divisors, same packing
//   rsp_valid    out  N_REQ       one-hot, 1-cycle pulse: result for requester i
//   rsp_result   out  BITS        quotient; valid only while rsp_valid != 0
//   rsp_err      out  1           qualifies rsp_valid; 1 = aborted by watchdog
//   div_start    out  1           to the core's reset pin
//   div_dividend out  BITS        to the core's dividendo
//   div_divisor  out  BITS        to the core's divisor
//   div_result   in   BITS        from the core's result
//   div_ready    in   1           from the core's ready
// BEHAVIOUR
//   Reset values:
//   - req_ready=0, rsp_valid=0, rsp_result=0, rsp_err=0.
//   - div_dividend=0, div_divisor=0, rr pointer=0, state=IDLE.
//   - div_start = reset | start_pulse, so the core is held initialised while reset is high.
//   FSM IDLE -> START -> WAIT -> RESP -> IDLE.
//   IDLE:
//   - Scan req_valid from ptr upward, modulo N_REQ; the first asserted index g wins.
//   - req_ready[g]=1 is combinational in the same cycle; no grant if all valid bits are 0.
//   - At the edge: latch the operands of g into div_dividend/div_divisor, store g, set ptr=(g+1)%N_REQ.
//   START (1 cycle): div_start=1; operands are already stable.
//   WAIT:
//   - div_start=0; operands held unchanged.
//   - div_ready is first sampled in the cycle after START, because the core clears ready on the start edge.
//   - On div_ready=1: rsp_result<=div_result, rsp_err<=0, go to RESP.
//   RESP (1 cycle): rsp_valid[g]=1; no new grant in this cycle. Next state IDLE.
//   Latency:
//   - acceptance edge -> rsp_valid = 2 + W cycles, where W = WAIT cycles until div_ready.
//   - Minimum back-to-back throughput: one request per 4 cycles.
//   Boundary conditions:
//   - req_ready is never asserted outside IDLE.
//   - req_valid may drop while not accepted; no penalty and the pointer does not move.
//   - Dividend 0 or divisor 0 is passed through unmodified; the core returns 0.
//   - reset mid-operation: return to IDLE immediately and drop any pending result. No rsp_valid is issued for the aborted request.
//   - Only one requester has rsp_valid per cycle; rsp_result is shared.
// CONFIGURATION
//   SAR_DIV_ARB_TIMEOUT_EN defined:
//   - A WAIT-cycle counter runs; it is cleared on entry to WAIT.
//   - At count == TIMEOUT_CYCLES-1 without div_ready: rsp_result<={BITS{1'b1}}, rsp_err<=1, go to RESP.
//   - The core is restarted on the next grant via START.
//   SAR_DIV_ARB_TIMEOUT_EN undefined:
//   - No counter; WAIT lasts until div_ready.
//   - rsp_err is tied to 0.
// TESTING
//   Single request:
//   - req_valid[0], 100/10 -> req_ready[0] same cycle.
//   - div_start 1 cycle later for exactly 1 cycle.
//   - rsp_valid=4'b0001 with rsp_result=10.
//   All valid held high, ptr=0 -> grants in order 0,1,2,3,0; each rsp_valid bit is one-hot and matches its grant.
//   Zero operands:
//   - 0/5 -> rsp_result=0, rsp_err=0.
//   - 5/0 -> rsp_result=0.
//   req_valid[2] rises during WAIT of req 1 -> req_ready[2] stays 0 until IDLE; granted next, operands of req 1 stay stable.
//   reset asserted in WAIT -> next cycle state IDLE, all outputs at reset values, no rsp_valid for the aborted request.
//   With SAR_DIV_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, div_ready forced 0 -> rsp_valid after 8 WAIT cycles with rsp_err=1, rsp_result=16'hFFFF.

Source files
------------

// File: rtl/sar_div_arbiter.sv
// Round-robin arbiter that shares one SAR divider core among N_REQ requesters.
// Optional WAIT watchdog is enabled by defining SAR_DIV_ARB_TIMEOUT_EN.
module sar_div_arbiter #(
    parameter int BITS           = 16,
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [N_REQ*BITS-1:0]   req_dividend_i,
    input  logic [N_REQ*BITS-1:0]   req_divisor_i,
    output logic [N_REQ-1:0]        rsp_valid_o,
    output logic [BITS-1:0]         rsp_result_o,
    output logic                    rsp_err_o,
    output logic                    div_start_o,
    output logic [BITS-1:0]         div_dividend_o,
    output logic [BITS-1:0]         div_divisor_o,
    input  logic [BITS-1:0]         div_result_i,
    input  logic                    div_ready_i
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     gnt_q, gnt_d;
    logic [BITS-1:0]   dvd_q, dvd_d;
    logic [BITS-1:0]   dvs_q, dvs_d;
    logic [BITS-1:0]   res_q, res_d;

    logic              grant_found;
    logic [PW-1:0]     grant_idx;
    logic [PW:0]       scan_sum;
    logic [BITS-1:0]   dvd_arr [N_REQ];
    logic [BITS-1:0]   dvs_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign dvd_arr[gi]     = req_dividend_i[gi*BITS +: BITS];
            assign dvs_arr[gi]     = req_divisor_i[gi*BITS +: BITS];
            assign req_ready_o[gi] = !reset && (state_q == S_IDLE) && grant_found
                                     && (grant_idx == PW'(gi));
            assign rsp_valid_o[gi] = !reset && (state_q == S_RESP) && (gnt_q == PW'(gi));
        end
    endgenerate

    // First asserted request at or above the pointer, wrapping modulo N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (scan_sum >= (PW+1)'(N_REQ)) begin
                scan_sum = scan_sum - (PW+1)'(N_REQ);
            end
            if (!grant_found && req_valid_i[scan_sum[PW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_sum[PW-1:0];
            end
        end
    end

`ifdef SAR_DIV_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
`ifdef SAR_DIV_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    dvd_d   = dvd_arr[grant_idx];
                    dvs_d   = dvs_arr[grant_idx];
                    gnt_d   = grant_idx;
                    ptr_d   = (grant_idx == PW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
`ifdef SAR_DIV_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Core ready is only trusted after the start edge has cleared it.
                if (div_ready_i) begin
                    res_d   = div_result_i;
`ifdef SAR_DIV_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_RESP;
                end
`ifdef SAR_DIV_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES-1)) begin
                    res_d   = '1;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
`ifdef SAR_DIV_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
`ifdef SAR_DIV_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // The core's reset pin is also held while the arbiter itself is in reset.
    assign div_start_o    = reset | (state_q == S_START);
    assign div_dividend_o = dvd_q;
    assign div_divisor_o  = dvs_q;
    assign rsp_result_o   = res_q;
`ifdef SAR_DIV_ARB_TIMEOUT_EN
    assign rsp_err_o      = err_q;
`else
    assign rsp_err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_sar_div_arbiter.sv
// Bench for sar_div_arbiter: divider-core model, transaction-level reference model, directed tests.
// The watchdog test runs only when SAR_DIV_ARB_TIMEOUT_EN is defined.
module tb_sar_div_arbiter;

    localparam int BITS = 16;
    localparam int N    = 4;
    localparam int TO   = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [N-1:0]        req_valid = '0;
    logic [N-1:0]        req_ready;
    logic [N*BITS-1:0]   req_dividend = '0;
    logic [N*BITS-1:0]   req_divisor = '0;
    logic [N-1:0]        rsp_valid;
    logic [BITS-1:0]     rsp_result;
    logic                rsp_err;
    logic                div_start;
    logic [BITS-1:0]     div_dividend;
    logic [BITS-1:0]     div_divisor;
    logic [BITS-1:0]     div_result = '0;
    logic                div_ready = 1'b0;

    always #5 clk = ~clk;

    sar_div_arbiter #(.BITS(BITS), .N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_dividend_i(req_dividend), .req_divisor_i(req_divisor),
        .rsp_valid_o(rsp_valid), .rsp_result_o(rsp_result), .rsp_err_o(rsp_err),
        .div_start_o(div_start), .div_dividend_o(div_dividend), .div_divisor_o(div_divisor),
        .div_result_i(div_result), .div_ready_i(div_ready)
    );

    function automatic logic [BITS-1:0] qdiv(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        return (b == '0) ? '0 : a / b;
    endfunction

    // Divider core: start clears ready; ready rises core_lat+1 cycles into WAIT.
    int core_lat   = 1;
    bit core_stall = 1'b0;
    int core_cnt   = 0;
    always @(posedge clk) begin
        if (div_start) begin
            div_ready <= 1'b0;
            core_cnt  <= core_lat;
        end else if (core_cnt > 1) begin
            core_cnt  <= core_cnt - 1;
        end else if (core_cnt == 1 && !core_stall) begin
            div_ready  <= 1'b1;
            div_result <= qdiv(div_dividend, div_divisor);
            core_cnt   <= 0;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: grant rule, latency 2+W, quotient from driven operands.
    int              cyc = 0;
    bit              m_busy = 1'b0;
    bit              m_after_reset = 1'b0;
    int              m_ptr = 0;
    int              m_g = 0;
    int              m_start = 0;
    int              m_rsp = 0;
    logic [BITS-1:0] m_a, m_b, m_res;
    bit              m_err;
    int              rsp_count = 0;

    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rsp;
        logic         exp_start;
        bit           found;
        int           g;
        exp_ready = '0;
        exp_rsp   = '0;
        exp_start = reset;
        found     = 1'b0;
        g         = 0;
        if (reset) begin
            m_busy        = 1'b0;
            m_ptr         = 0;
            m_after_reset = 1'b1;
        end else begin
            if (m_after_reset) begin
                check("post_reset_result", rsp_result, 0);
                check("post_reset_dividend", div_dividend, 0);
                check("post_reset_divisor", div_divisor, 0);
                check("post_reset_err", rsp_err, 0);
                m_after_reset = 1'b0;
            end
            if (!m_busy) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (!found && req_valid[j]) begin
                        found = 1'b1;
                        g     = j;
                    end
                end
                if (found) begin
                    exp_ready[g] = 1'b1;
                    m_g     = g;
                    m_a     = req_dividend[g*BITS +: BITS];
                    m_b     = req_divisor[g*BITS +: BITS];
                    m_res   = core_stall ? '1 : qdiv(m_a, m_b);
                    m_err   = core_stall;
                    m_start = cyc + 1;
                    m_rsp   = cyc + 2 + (core_stall ? TO : core_lat + 1);
                    m_ptr   = (g + 1) % N;
                    m_busy  = 1'b1;
                end
            end else begin
                if (cyc == m_start) exp_start = 1'b1;
                check("held_dividend", div_dividend, m_a);
                check("held_divisor", div_divisor, m_b);
                if (cyc == m_rsp) begin
                    exp_rsp[m_g] = 1'b1;
                    check("rsp_result", rsp_result, m_res);
                    check("rsp_err", rsp_err, m_err);
                    m_busy = 1'b0;
                end
            end
        end
        check("req_ready", req_ready, exp_ready);
        check("rsp_valid", rsp_valid, exp_rsp);
        check("div_start", div_start, exp_start);
        if (rsp_valid != '0) begin
            rsp_count++;
            $display("rsp: t=%0t valid=%b result=%0d err=%0b", $time, rsp_valid, rsp_result, rsp_err);
        end
        cyc++;
    end

    // Offer request i, wait for its grant, then withdraw it on the transfer edge.
    task automatic do_req(input int i, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        bit ok;
        ok = 1'b0;
        req_dividend[i*BITS +: BITS] = a;
        req_divisor[i*BITS +: BITS]  = b;
        req_valid[i] = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (req_ready[i]) ok = 1'b1;
        end
        if (!ok) check("grant_timeout", 0, 1);
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        bit ok;
        ok = 1'b0;
        n  = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            n++;
            if (rsp_valid != '0) ok = 1'b1;
        end
        if (!ok) check("rsp_timeout", 0, 1);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int n;
        int grants [5];
        int exp_order [5];
        int gcount;
        int rc;
        bit seen;
        exp_order = '{0, 1, 2, 3, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_req_ready", req_ready, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_div_start", div_start, 1);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single request 100/10
        core_lat = 1;
        do_req(0, 16'd100, 16'd10);
        wait_rsp(n);
        check("single_result", rsp_result, 10);
        check("single_valid", rsp_valid, 4'b0001);
        check("single_latency", n, 4);
        $display("txn single: 100/10 -> %0d latency=%0d", rsp_result, n);

        // All requesters valid from ptr=0
        do_reset(1);
        for (int i = 0; i < N; i++) begin
            req_dividend[i*BITS +: BITS] = 16'(1000 + 37*i);
            req_divisor[i*BITS +: BITS]  = 16'(i + 3);
        end
        req_valid = '1;
        gcount = 0;
        for (int t = 0; t < 200 && gcount < 5; t++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    grants[gcount] = i;
                    gcount++;
                end
            end
        end
        @(posedge clk);
        #1 req_valid = '0;
        check("rr_grant_count", gcount, 5);
        for (int i = 0; i < 5; i++) begin
            check("rr_order", grants[i], exp_order[i]);
            $display("txn rr: grant #%0d -> requester %0d", i, grants[i]);
        end
        wait_rsp(n);
        check("rr_last_result", rsp_result, 333);

        // Zero operands
        do_req(3, 16'd0, 16'd5);
        wait_rsp(n);
        check("zero_dividend_result", rsp_result, 0);
        check("zero_dividend_err", rsp_err, 0);
        $display("txn zero: 0/5 -> %0d", rsp_result);
        do_req(0, 16'd5, 16'd0);
        wait_rsp(n);
        check("zero_divisor_result", rsp_result, 0);
        $display("txn zero: 5/0 -> %0d", rsp_result);

        // Request 2 arrives while request 1 is in WAIT
        core_lat = 5;
        do_req(1, 16'd300, 16'd7);
        @(negedge clk);
        @(posedge clk);
        #1 req_dividend[2*BITS +: BITS] = 16'd50;
        req_divisor[2*BITS +: BITS] = 16'd5;
        req_valid[2] = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            check("no_ready_while_busy", req_ready[2], 0);
            if (rsp_valid != '0) seen = 1'b1;
        end
        check("busy_rsp_seen", seen, 1);
        check("busy_req1_result", rsp_result, 42);
        check("busy_req1_valid", rsp_valid, 4'b0010);
        @(negedge clk);
        check("req2_granted_next", req_ready, 4'b0100);
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        wait_rsp(n);
        check("req2_result", rsp_result, 10);
        $display("txn late: 300/7 -> 42, then 50/5 -> %0d", rsp_result);

        // Reset while in WAIT drops the pending result
        core_lat = 6;
        do_req(2, 16'd1000, 16'd7);
        repeat (3) @(negedge clk);
        rc = rsp_count;
        do_reset(1);
        repeat (15) @(negedge clk);
        check("abort_no_rsp", rsp_count, rc);
        $display("txn abort: responses before=%0d after=%0d", rc, rsp_count);

`ifdef SAR_DIV_ARB_TIMEOUT_EN
        // Watchdog: core never becomes ready
        core_stall = 1'b1;
        do_req(1, 16'd9, 16'd3);
        wait_rsp(n);
        check("timeout_err", rsp_err, 1);
        check("timeout_result", rsp_result, 16'hFFFF);
        check("timeout_latency", n, 2 + TO);
        $display("txn timeout: err=%0b result=%0h latency=%0d", rsp_err, rsp_result, n);
        core_stall = 1'b0;
        core_lat   = 1;
        do_req(3, 16'd81, 16'd9);
        wait_rsp(n);
        check("after_timeout_result", rsp_result, 9);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
